scale_select: RTL and testbench



---
 rtl/scale_select_pkg.sv | 13 +
 rtl/scale_select_abs_mag.sv | 14 +
 rtl/scale_select.sv | 107 ++++++++++
 tb/tb_scale_select.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/scale_select_pkg.sv
// Shared definitions for the scale_select block: the signed data word width
// that kernel_scale produces and the default scale-output width derived from it.
package scale_select_pkg;

  // Width of the signed word the scaled samples must fit into.
  localparam int BIT_DATA = 8;

  // Width needed to hold a shift amount in 0 .. bit_in - BIT_DATA.
  function automatic int scale_width(input int bit_in);
    return $clog2(bit_in - BIT_DATA) + 1;
  endfunction

endpackage

// File: rtl/scale_select_abs_mag.sv
// One's-complement magnitude of a signed sample: ~x for negatives, x otherwise.
// -2^(BIT_IN-1) maps to 2^(BIT_IN-1)-1, so the result never overflows and a
// negative power of two lands in the same range as the positive one below it.
module scale_select_abs_mag #(
  parameter int BIT_IN = 16
) (
  input  logic signed [BIT_IN-1:0] i_x,
  output logic        [BIT_IN-2:0] o_mag
);

  // XOR with the replicated sign bit inverts negatives and passes positives.
  assign o_mag = i_x[BIT_IN-2:0] ^ {(BIT_IN-1){i_x[BIT_IN-1]}};

endmodule

// File: rtl/scale_select.sv
// Tracks the peak magnitude of one window of wide signed accumulator samples,
// then finds the smallest arithmetic right shift that fits every sample into a
// signed BIT_DATA word. The shift is offered on a valid/ready handshake.
module scale_select
  import scale_select_pkg::*;
#(
  parameter int BIT_IN = 16,
  parameter int BIT_SH = scale_width(BIT_IN)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BIT_IN-1:0] in_x,
  input  logic                     in_last,
  output logic                     scale_valid,
  input  logic                     scale_ready,
  output logic        [BIT_SH-1:0] scale,
  output logic        [BIT_IN-2:0] peak
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    CALC  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_scale_valid;
  logic [BIT_SH-1:0] r_scale;
  logic [BIT_IN-2:0] r_peak;
  logic [BIT_IN-2:0] r_work;

  logic [BIT_IN-2:0] w_mag;
  logic [BIT_IN-2:0] w_max;
  logic              w_fits;

  scale_select_abs_mag #(
    .BIT_IN (BIT_IN)
  ) u_abs_mag (
    .i_x   (in_x),
    .o_mag (w_mag)
  );

  // Running peak including the sample currently on the input.
  assign w_max  = (w_mag > r_peak) ? w_mag : r_peak;

  // The working value fits once every bit above the signed data range is clear.
  assign w_fits = ~|r_work[BIT_IN-2:BIT_DATA-1];

  // Window accumulation, shift search and result hold, all outputs registered.
  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ACCUM;
      r_in_ready    <= 1'b1;
      r_scale_valid <= 1'b0;
      r_scale       <= '0;
      r_peak        <= '0;
      r_work        <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (in_valid) begin
            r_peak <= w_max;
            if (in_last) begin
              r_work     <= w_max;
              r_scale    <= '0;
              r_in_ready <= 1'b0;
              r_state    <= CALC;
            end
          end
        end
        CALC: begin
          if (!w_fits) begin
            r_work  <= r_work >> 1;
            r_scale <= r_scale + BIT_SH'(1);
          end else begin
            r_scale_valid <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (scale_ready) begin
            r_scale_valid <= 1'b0;
            r_peak        <= '0;
            r_in_ready    <= 1'b1;
            r_state       <= ACCUM;
          end
        end
        default: begin
          r_in_ready    <= 1'b1;
          r_scale_valid <= 1'b0;
          r_state       <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign scale_valid = r_scale_valid;
  assign scale       = r_scale;
  assign peak        = r_peak;

endmodule

// File: tb/tb_scale_select.sv
// Self-checking bench for scale_select: directed corner windows plus random
// windows scored against a plain-arithmetic reference of peak, scale, latency.
module tb_scale_select;
  import scale_select_pkg::*;

  localparam int BIT_IN = 16;
  localparam int BIT_SH = 4;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [BIT_IN-1:0] in_x = '0;
  logic                     in_last = 1'b0;
  logic                     scale_valid;
  logic                     scale_ready = 1'b0;
  logic        [BIT_SH-1:0] scale;
  logic        [BIT_IN-2:0] peak;

  int n_tests = 0;
  int n_fail  = 0;

  scale_select #(
    .BIT_IN (BIT_IN),
    .BIT_SH (BIT_SH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_last     (in_last),
    .scale_valid (scale_valid),
    .scale_ready (scale_ready),
    .scale       (scale),
    .peak        (peak)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: magnitude |x| with negatives counted as -x-1, peak is the max.
  function automatic int ref_peak(input int win[$]);
    int pk = 0;
    foreach (win[i]) begin
      int m = (win[i] < 0) ? (-win[i] - 1) : win[i];
      if (m > pk) pk = m;
    end
    return pk;
  endfunction

  // Reference: smallest right shift bringing the peak within the signed data range.
  function automatic int ref_scale(input int pk);
    int s = 0;
    while ((pk >> s) > (2 ** (BIT_DATA - 1) - 1)) s++;
    return s;
  endfunction

  // Offer one sample and return once it has been accepted on a rising edge.
  task automatic send(input int x, input logic last);
    int guard = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_x     = BIT_IN'(x);
    in_last  = last;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("send_timeout", 32'(guard), 32'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send a whole window, then check latency, scale and peak of the result.
  task automatic run_window(input string tag, input int win[$]);
    int pk  = ref_peak(win);
    int sc  = ref_scale(pk);
    int lat = 0;
    foreach (win[i]) send(win[i], (i == win.size() - 1));
    while (!scale_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(1 + sc));
    check({tag, "_scale"}, 32'(scale), 32'(sc));
    check({tag, "_peak"}, 32'(peak), 32'(pk));
  endtask

  // Take the result and confirm the block re-opens for input.
  task automatic consume(input string tag);
    @(negedge clock);
    scale_ready = 1'b1;
    @(posedge clock);
    #1;
    scale_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(scale_valid), 32'd0);
    check({tag, "_peak_after"}, 32'(peak), 32'd0);
  endtask

  initial begin
    int win[$];
    int seen;
    logic [BIT_SH-1:0] held_scale;
    logic [BIT_IN-2:0] held_peak;

    // Reset state.
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_valid", 32'(scale_valid), 32'd0);

    // 1: asynchronous reset mid-stream, checked between clock edges.
    send(3000, 1'b0);
    send(-500, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_valid", 32'(scale_valid), 32'd0);
    check("t1_scale", 32'(scale), 32'd0);
    check("t1_peak", 32'(peak), 32'd0);
    #3 reset = 1'b1;

    // 2: windows that already fit.
    win = '{10, -20, 100, 127};
    run_window("t2a", win);
    consume("t2a");
    win = '{-128};
    run_window("t2b", win);
    consume("t2b");

    // 3: windows needing a shift.
    win = '{300, -129};
    run_window("t3a", win);
    consume("t3a");
    win = '{128};
    run_window("t3b", win);
    consume("t3b");

    // 4: most negative sample needs the full shift range.
    win = '{-32768};
    run_window("t4", win);

    // 5: backpressure while a sender keeps offering samples.
    held_scale = scale;
    held_peak  = peak;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_x     = BIT_IN'($urandom);
      in_last  = 1'(i == 4);
      @(posedge clock);
      #1;
      check("t5_scale_hold", 32'(scale), 32'(held_scale));
      check("t5_peak_hold", 32'(peak), 32'(held_peak));
      check("t5_in_ready", 32'(in_ready), 32'd0);
      check("t5_valid_hold", 32'(scale_valid), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume("t5");
    win = '{5};
    run_window("t5b", win);
    consume("t5b");

    // 6: reset during the shift search discards the result.
    send(-32768, 1'b1);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_valid_rst", 32'(scale_valid), 32'd0);
    check("t6_ready_rst", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (scale_valid) seen++;
    end
    check("t6_no_valid", 32'(seen), 32'd0);
    win = '{64};
    run_window("t6b", win);
    consume("t6b");

    // Random windows of varied length and magnitude.
    for (int w = 0; w < 25; w++) begin
      int len = $urandom_range(1, 6);
      win = {};
      for (int i = 0; i < len; i++) begin
        logic signed [BIT_IN-1:0] v;
        v = BIT_IN'($urandom);
        v = v >>> $urandom_range(0, 15);
        win.push_back(int'(v));
      end
      run_window($sformatf("rnd%0d", w), win);
      consume($sformatf("rnd%0d", w));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
